// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for a show-ahead read port; the default read port is registered.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Handshake: a write is taken when wr_en is high and the FIFO is not full, or when a read
  // is taken in the same cycle; a read is taken when rd_en is high and the FIFO is not empty.
  // There is no empty bypass: write+read on an empty FIFO stores the word and flags underflow.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));
  assign almost_full  = (count >= CNT_W'(AF_THRESH));

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error event wins over a clear in the same cycle.
      if (wr_en & ~wr_acc) overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd_en & empty)   underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule
